// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Opcode constants, FSM state type, instruction length and PC step.
package ifu_pkg;

  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// Fetch bus: imem request/response, redirect, decode handshake.
// master = fetch unit side, slave = memory/decode/branch side.
interface ifu_if
  import ifu_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [6:0]      opcode;

  modport master (
    output imem_req_valid, imem_req_addr,
    output if_valid, if_instr, if_pc, opcode,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_instr, if_pc, opcode,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// Sync FIFO holding {pc, instr}; flush clears, head read from storage.
// Ports: clk, reset, push/pushData, pop, flush, head, count.
module ifu_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= pushData;
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, in-order imem reads, buffered instr/PC to decode.
// Ports: clk, reset, bus (ifu_if.master); IFU_PERF_CNT_EN adds perf_*.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  ifu_if.master       bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_stall,
  output logic [31:0] perf_redirects
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  ifu_state_e state, stateNext;
  logic [XLEN-1:0] pc, pcNext;
  logic [CW-1:0] outstanding, outstandingNext;
  logic [CW-1:0] drop, dropNext;
  logic [CW-1:0] count;
  logic [CW:0] inUse;
  logic reqValid, accept, rspHit;
  logic push, pop, headValid;
  logic [XLEN-1:0] rspAddr;
  logic [XLEN+ILEN-1:0] head;
  logic [ILEN-1:0] instr;

  assign inUse = {1'b0, outstanding} + {1'b0, count};
  assign reqValid = !reset && state == FETCH
                 && !bus.redirect_valid
                 && inUse < DEPTH_W;
  assign accept = reqValid && bus.imem_req_ready;
  assign rspHit = bus.imem_rsp_valid && outstanding != '0;

  // In-order and drained after every redirect, so the oldest
  // live request sits `outstanding` words behind pc.
  assign rspAddr = pc - (XLEN'(outstanding) << 2);

  assign push = rspHit && state == FETCH
             && !bus.redirect_valid;
  assign headValid = count != '0;
  assign pop = headValid && bus.if_ready;

  ifu_fifo #(
    .W    (XLEN + ILEN),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pushData({rspAddr, bus.imem_rsp_data}),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .head    (head),
    .count   (count)
  );

  always_comb begin
    stateNext = state;
    pcNext = pc;
    dropNext = drop;
    outstandingNext = outstanding + CW'(accept)
                    - CW'(rspHit);
    if (accept) pcNext = pc + XLEN'(PC_STEP);
    unique case (state)
      FETCH: begin
        if (bus.redirect_valid) begin
          dropNext = outstandingNext;
          if (outstandingNext != '0) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (rspHit) dropNext = drop - 1'b1;
        if (bus.redirect_valid) dropNext = outstandingNext;
        if (dropNext == '0) stateNext = FETCH;
      end
    endcase
    if (bus.redirect_valid) pcNext = bus.redirect_pc & ALIGN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC & ALIGN;
      outstanding <= '0;
      drop <= '0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      outstanding <= outstandingNext;
      drop <= dropNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      orphanRsp: assert (!(bus.imem_rsp_valid
                           && outstanding == '0));
    end
  end

  assign instr = headValid ? head[ILEN-1:0] : '0;
  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr = pc;
  assign bus.if_valid = headValid;
  assign bus.if_instr = instr;
  assign bus.if_pc = headValid ? head[XLEN+ILEN-1:ILEN] : '0;
  assign bus.opcode = instr[6:0];

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_stall <= '0;
      perf_redirects <= '0;
    end else begin
      if (!headValid && state != DRAIN
          && perf_fetch_stall != '1)
        perf_fetch_stall <= perf_fetch_stall + 1'b1;
      if (bus.redirect_valid && perf_redirects != '1)
        perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule
